// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: single-outstanding imem read per PC, holds the
// word for execute, pulses exec_enable on retire, parks in a sticky fault state.
module instr_fetch_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        exec_stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        exec_enable,
   output logic        fetch_fault,
   output logic [1:0]  fault_cause
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   // Counter holds the number of completed WAIT cycles, so the limit is hit
   // on the cycle where it reads TIMEOUT_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic             req_valid_q, req_valid_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      instr_q, instr_d;
   logic             instr_valid_q, instr_valid_d;
   logic             fault_q, fault_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d       = state_q;
      req_valid_d   = req_valid_q;
      addr_d        = addr_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      fault_d       = fault_q;
      cause_d       = cause_q;
      cnt_d         = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pc[1:0] != 2'b00) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
               cause_d = CAUSE_MISALIGN;
            end else begin
               state_d     = S_REQ;
               req_valid_d = 1'b1;
               addr_d      = pc;
            end
         end
         S_REQ: begin
            // Address and valid stay registered until the handshake.
            if (req_valid_q && imem_req_ready) begin
               state_d     = S_WAIT;
               req_valid_d = 1'b0;
               cnt_d       = '0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
                  cause_d = CAUSE_BUSERR;
               end else begin
                  state_d       = S_HOLD;
                  instr_d       = imem_rsp_data;
                  instr_valid_d = 1'b1;
               end
            end else if (cnt_q >= CNT_LAST) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_HOLD: begin
            if (!exec_stall) begin
               state_d       = S_IDLE;
               instr_valid_d = 1'b0;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         req_valid_q   <= 1'b0;
         addr_q        <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
         cause_q       <= 2'b00;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         req_valid_q   <= req_valid_d;
         addr_q        <= addr_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
         cause_q       <= cause_d;
         cnt_q         <= cnt_d;
      end
   end

   // Retire is combinational so PC advances on the same edge HOLD exits.
   assign exec_enable    = (state_q == S_HOLD) && !exec_stall;
   assign imem_req_valid = req_valid_q;
   assign imem_addr      = addr_q;
   assign instr          = instr_q;
   assign instr_valid    = instr_valid_q;
   assign fetch_fault    = fault_q;
   assign fault_cause    = cause_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Vector-table bench for instr_fetch_ctrl: per-cycle expectations queued at
// drive time and compared on the falling edge, plus handshake/retire counts.
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = '0;
   logic        exec_stall = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_rsp_err = 1'b0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        exec_enable;
   logic        fetch_fault;
   logic [1:0]  fault_cause;

   instr_fetch_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .pc(pc), .exec_stall(exec_stall),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .instr(instr), .instr_valid(instr_valid), .exec_enable(exec_enable),
      .fetch_fault(fetch_fault), .fault_cause(fault_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic        rst;
      logic [31:0] pc;
      logic        st, rdy, rv, re;
      logic [31:0] rdata;
      logic        rqv;
      logic [31:0] addr;
      logic        iv, ci;
      logic [31:0] ins;
      logic        en, flt;
      logic [1:0]  cause;
   } vec_t;

   localparam logic [31:0] D1  = 32'h00500093;
   localparam logic [31:0] D2  = 32'h00a00113;
   localparam logic [31:0] D3  = 32'h002081b3;
   localparam logic [31:0] D5  = 32'h00c00213;
   localparam logic [31:0] BAD = 32'hdeadbeef;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   hs_cnt = 0;
   int   en_cnt = 0;
   int   dbl_en = 0;
   logic en_prev = 1'b0;

   task automatic add(input logic rst, input logic [31:0] p, input logic st, input logic rdy,
                      input logic rv, input logic re, input logic [31:0] rd,
                      input logic rqv, input logic [31:0] a, input logic iv, input logic ci,
                      input logic [31:0] ins, input logic en, input logic flt, input logic [1:0] c);
      vec_t v;
      v.idx = vecs.size(); v.rst = rst; v.pc = p; v.st = st; v.rdy = rdy; v.rv = rv; v.re = re;
      v.rdata = rd; v.rqv = rqv; v.addr = a; v.iv = iv; v.ci = ci; v.ins = ins; v.en = en;
      v.flt = flt; v.cause = c;
      vecs.push_back(v);
   endtask

   // Idle-looking cycle: inputs pc/ready only, every output expected low.
   task automatic add0(input logic rst, input logic [31:0] p);
      add(rst, p, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         vec_t e;
         logic ok;
         e = exp_q.pop_front();
         ok = (imem_req_valid === e.rqv) && (instr_valid === e.iv) && (exec_enable === e.en) &&
              (fetch_fault === e.flt) && (fault_cause === e.cause) &&
              (!e.rqv || imem_addr === e.addr) && (!e.ci || instr === e.ins);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL vec%0d: got rqv=%b addr=%h iv=%b ins=%h en=%b flt=%b cause=%0d, want rqv=%b addr=%h iv=%b ins=%h en=%b flt=%b cause=%0d",
                     e.idx, imem_req_valid, imem_addr, instr_valid, instr, exec_enable, fetch_fault,
                     fault_cause, e.rqv, e.addr, e.iv, e.ins, e.en, e.flt, e.cause);
         end
      end
      if (!reset) begin
         if (imem_req_valid && imem_req_ready) hs_cnt++;
         if (exec_enable) begin
            en_cnt++;
            if (en_prev) dbl_en++;
         end
         en_prev = exec_enable;
      end else begin
         en_prev = 1'b0;
      end
   end

   initial begin
      // Basic fetch, zero wait states
      add0(0, 32'h10);                                              // 0 IDLE
      add(0, 32'h10, 0, 1, 0, 0, 0,  1, 32'h10, 0, 0, 0, 0, 0, 0);  // 1 REQ accepted
      add(0, 32'h10, 0, 0, 1, 0, D1, 0, 0, 0, 0, 0, 0, 0, 0);       // 2 WAIT rsp
      add(0, 32'h10, 0, 0, 0, 0, 0,  0, 0, 1, 1, D1, 1, 0, 0);      // 3 HOLD retire
      // Backpressure: 3 cycles not ready
      add0(0, 32'h14);                                              // 4
      for (int i = 0; i < 3; i++) add(0, 32'h14, 0, 0, 0, 0, 0, 1, 32'h14, 0, 0, 0, 0, 0, 0);
      add(0, 32'h14, 0, 1, 0, 0, 0,  1, 32'h14, 0, 0, 0, 0, 0, 0);  // 8
      add(0, 32'h14, 1, 0, 1, 0, D2, 0, 0, 0, 0, 0, 0, 0, 0);       // 9
      // Stall 5 cycles in HOLD
      for (int i = 0; i < 5; i++) add(0, 32'h14, 1, 0, 0, 0, 0, 0, 0, 1, 1, D2, 0, 0, 0);
      add(0, 32'h14, 0, 0, 0, 0, 0,  0, 0, 1, 1, D2, 1, 0, 0);      // 15 retire
      add(0, 32'h18, 0, 0, 0, 0, 0,  0, 0, 0, 1, D2, 0, 0, 0);      // 16 instr kept
      // Response during REQ is ignored; response on 4th WAIT cycle wins
      add(0, 32'h18, 0, 1, 1, 1, BAD, 1, 32'h18, 0, 0, 0, 0, 0, 0); // 17
      for (int i = 0; i < 3; i++) add0(0, 32'h18);
      add(0, 32'h18, 0, 0, 1, 0, D3, 0, 0, 0, 0, 0, 0, 0, 0);       // 21
      add(0, 32'h18, 0, 0, 0, 0, 0,  0, 0, 1, 1, D3, 1, 0, 0);      // 22
      // Timeout after 4 WAIT cycles
      add0(0, 32'h1c);
      add(0, 32'h1c, 0, 1, 0, 0, 0,  1, 32'h1c, 0, 0, 0, 0, 0, 0);  // 24
      for (int i = 0; i < 4; i++) add0(0, 32'h1c);
      add(0, 32'h1c, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2'd3);    // 29
      add(0, 32'h1c, 0, 1, 1, 0, D5, 0, 0, 0, 0, 0, 0, 1, 2'd3);    // 30 sticky
      // Misaligned PC
      add0(1, 32'h6);
      add0(0, 32'h6);
      for (int i = 0; i < 2; i++) add(0, 32'h6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1);
      // Bus error
      add0(1, 32'h20);
      add0(0, 32'h20);
      add(0, 32'h20, 0, 1, 0, 0, 0,  1, 32'h20, 0, 0, 0, 0, 0, 0);  // 37
      add(0, 32'h20, 0, 0, 1, 1, BAD, 0, 0, 0, 0, 0, 0, 0, 0);      // 38
      add(0, 32'h20, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2'd2);    // 39
      // Reset mid-WAIT, late response ignored, fresh request with current pc
      add0(1, 32'h40);
      add0(0, 32'h40);
      add(0, 32'h40, 0, 1, 0, 0, 0,  1, 32'h40, 0, 0, 0, 0, 0, 0);  // 42
      add0(0, 32'h40);                                              // 43 WAIT
      add0(1, 32'h40);                                              // 44 async reset
      add(0, 32'h44, 0, 0, 1, 0, BAD, 0, 0, 0, 0, 0, 0, 0, 0);      // 45 late rsp
      add(0, 32'h44, 0, 1, 1, 0, BAD, 1, 32'h44, 0, 0, 0, 0, 0, 0); // 46
      add(0, 32'h44, 0, 0, 1, 0, D5, 0, 0, 0, 0, 0, 0, 0, 0);       // 47
      add(0, 32'h44, 0, 0, 0, 0, 0,  0, 0, 1, 1, D5, 1, 0, 0);      // 48
      add0(0, 32'h48);                                              // 49

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (imem_req_valid || instr_valid || exec_enable || fetch_fault || fault_cause != 2'd0 ||
          instr != 32'd0 || imem_addr != 32'd0) begin
         errors++;
         $display("FAIL reset_state: rqv=%b iv=%b en=%b flt=%b cause=%0d instr=%h addr=%h, want all zero",
                  imem_req_valid, instr_valid, exec_enable, fetch_fault, fault_cause, instr, imem_addr);
      end

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         reset          = vecs[i].rst;
         pc             = vecs[i].pc;
         exec_stall     = vecs[i].st;
         imem_req_ready = vecs[i].rdy;
         imem_rsp_valid = vecs[i].rv;
         imem_rsp_err   = vecs[i].re;
         imem_rsp_data  = vecs[i].rdata;
         exp_q.push_back(vecs[i]);
      end
      @(posedge clk);
      #1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      @(negedge clk);
      #1;

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d left, want 0", exp_q.size());
      end
      checks++;
      if (hs_cnt != 7) begin
         errors++;
         $display("FAIL handshakes: got %0d, want 7", hs_cnt);
      end
      checks++;
      if (en_cnt != 4) begin
         errors++;
         $display("FAIL retire_count: got %0d, want 4", en_cnt);
      end
      checks++;
      if (dbl_en != 0) begin
         errors++;
         $display("FAIL en_back_to_back: got %0d, want 0", dbl_en);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch-side counterpart of the program counter register; drives the `exec_enable` that PC consumes.
- Takes the current `pc` and issues a single-outstanding read to instruction memory over a valid/ready request channel and a valid response channel.
- Holds the returned word for the execute stage and pulses `exec_enable` for exactly one cycle per retired instruction.
- Detects misaligned PCs, bus errors and response timeouts, and parks in a sticky fault state.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT before a timeout fault. Legal range 1..65535.
- CNT_W, 16: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc  in  32  current program counter from the PC register.
- exec_stall  in  1  execute/memory stage busy; blocks retirement.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  request address.
- imem_rsp_valid  in  1  response word valid, single-cycle pulse.
- imem_rsp_data  in  32  response word.
- imem_rsp_err  in  1  bus error, qualified by imem_rsp_valid.
- instr  out  32  held instruction word.
- instr_valid  out  1  instr holds a fetched, not-yet-retired word.
- exec_enable  out  1  one-cycle retire pulse; PC advances on it.
- fetch_fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout.

Behaviour:
- Reset values: all outputs 0; state = IDLE; timeout counter 0. Reset mid-transaction abandons it; a late imem_rsp_valid after reset is ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE:
  - pc[1:0] != 0 -> FAULT, cause 01, no request issued.
  - otherwise -> REQ.
- REQ:
  - imem_req_valid = 1, imem_addr = pc, both registered.
  - imem_addr is stable while imem_req_valid = 1 and imem_req_ready = 0; valid is never dropped before acceptance.
  - Handshake (valid & ready) -> WAIT; counter cleared.
- WAIT:
  - imem_req_valid = 0; counter increments each cycle.
  - imem_rsp_valid & imem_rsp_err -> FAULT, cause 10.
  - imem_rsp_valid & !imem_rsp_err -> instr <= imem_rsp_data, instr_valid <= 1, -> HOLD.
  - Counter reaching TIMEOUT_CYCLES with no response -> FAULT, cause 11.
  - A response arriving in the same cycle the counter hits the limit wins; no fault.
- HOLD:
  - exec_stall = 1: stay; instr and instr_valid held.
  - exec_stall = 0: exec_enable = 1 for that cycle (combinational from state & !exec_stall); next cycle instr_valid = 0 and state -> IDLE.
  - instr keeps its last value after retire.
  - PC updates on the same edge as the retire, so IDLE samples the new pc.
- FAULT:
  - fetch_fault = 1; fault_cause holds.
  - No requests, no exec_enable; instr_valid = 0.
  - Exit only via reset.
- Latency: with a zero-wait-state memory (ready = 1, response the cycle after acceptance), instruction throughput is one retire per 4 cycles: IDLE, REQ, WAIT, HOLD.
- Responses outside WAIT are ignored and cause no state change.
- exec_enable is never asserted for more than one consecutive cycle.

Test Plan:
- Basic fetch: pc=0x00000010, ready=1, response 1 cycle later with data 0x00500093, stall=0.
  -> imem_addr=0x10 during REQ; instr=0x00500093; exec_enable single pulse 4 cycles after reset release.
- Backpressure: imem_req_ready low for 3 cycles.
  -> imem_req_valid held high and imem_addr constant for all 4 REQ cycles; one accepted request only.
- Stall: exec_stall high for 5 cycles in HOLD.
  -> instr_valid=1 and instr stable throughout; exec_enable rises the cycle stall drops, for exactly 1 cycle.
- Faults:
  - pc=0x00000006 -> fetch_fault=1, cause=01, imem_req_valid never asserted.
  - rsp_err=1 -> cause=10.
  - TIMEOUT_CYCLES=4 with no response -> cause=11 after 4 WAIT cycles.
  - Response on the 4th WAIT cycle -> no fault.
- Reset mid-WAIT: assert reset, then pulse imem_rsp_valid after release.
  -> outputs 0 immediately on reset; late response ignored; fresh request issued with the current pc.
